fetch_stage: RTL and testbench

Instruction-fetch front end for the CPU: owns the program counter, drives read requests into the synchronous instruction memory (`insMem`, one-cycle read latency), and delivers `{pc, instruction}` pairs to the decode / register-file stage over a valid/ready handshake. A two-entry skid queue absorbs the in-flight memory read when decode stalls. A redirect input (branch/jump target) flushes all in-flight and buffered fetches and restarts sequential fetch at the new address.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/fetch_stage_if.sv | 25 ++
 rtl/fetch_skid_fifo.sv | 50 +++++
 rtl/fetch_stage.sv | 66 ++++++
 tb/tb_fetch_stage.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch->decode entry type.
// Decode reuses these widths, so keep them in one place.
package cpu_pkg;
    localparam int ADDR_W = 32;
    localparam int INSN_W = 32;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;
    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INSN_W-1:0] insn;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory port, redirect input and the decode handshake.
// master = fetch side, slave = memory/decode/branch side.
interface fetch_stage_if;
    import cpu_pkg::*;

    logic              imem_rd_en;
    logic [ADDR_W-1:0] imem_rd_address;
    logic [INSN_W-1:0] imem_data_in;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_pc;
    logic [INSN_W-1:0] out_insn;

    modport master (
        output imem_rd_en, imem_rd_address, out_valid, out_pc, out_insn,
        input  imem_data_in, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_rd_en, imem_rd_address, out_valid, out_pc, out_insn,
        output imem_data_in, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_skid_fifo.sv
// Two-entry {pc, insn} skid queue; entry 0 is always the head, so the output is a plain register.
// Zero-latency head; caller guarantees no push when full and no pop when empty; flush drops everything.
module fetch_skid_fifo
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [1:0]   occ
);
    fetch_entry_t e0, e1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e0  <= '0;
            e1  <= '0;
            occ <= 2'd0;
        end else if (flush) begin
            occ <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) e0 <= push_entry;
                    else             e1 <= push_entry;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    e0  <= e1;
                    occ <= occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new entry lands behind whatever survives the pop.
                    if (occ == 2'd1) begin
                        e0 <= push_entry;
                    end else begin
                        e0 <= e1;
                        e1 <= push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head = e0;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues reads to a 1-cycle memory, presents {pc, insn} to decode.
// Request-to-present latency 2 cycles; stops issuing once buffered + in-flight reaches 2; redirect flushes.
module fetch_stage
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic [1:0]        occ;
    logic [2:0]        pending;
    logic              pop;
    logic              push;
    logic              issue;
    fetch_entry_t      head;
    fetch_entry_t      push_entry;

    assign pop = bus.out_valid & bus.out_ready;

    // Slots that will still be committed after this edge; never underflows since pop implies occ >= 1.
    assign pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign issue   = !reset && !bus.redirect_valid && (pending < 3'd2);
    assign push    = inflight && !bus.redirect_valid;

    assign push_entry.pc   = inflight_pc;
    assign push_entry.insn = bus.imem_data_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (bus.redirect_valid) begin
            pc_q     <= bus.redirect_pc & ALIGN_MASK;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc_q        <= pc_q + PC_STEP;
                inflight_pc <= pc_q;
            end
        end
    end

    fetch_skid_fifo u_skid (
        .clk        (clk),
        .reset      (reset),
        .flush      (bus.redirect_valid),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .occ        (occ)
    );

    assign bus.imem_rd_en      = issue;
    assign bus.imem_rd_address = pc_q;
    assign bus.out_valid       = (occ != 2'd0);
    assign bus.out_pc          = head.pc;
    assign bus.out_insn        = head.insn;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed and random checks of fetch_stage against an in-order delivered-PC stream model.
module tb_fetch_stage;
    import cpu_pkg::*;

    localparam logic [INSN_W-1:0] KEY = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;

    fetch_stage_if bus();

    fetch_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data for address a is a ^ KEY, one cycle after the request.
    always @(posedge clk) begin
        if (bus.imem_rd_en) bus.imem_data_in <= bus.imem_rd_address ^ KEY;
    end

    int n_assert = 0;
    int n_fail   = 0;
    int n_xfer   = 0;
    int cyc      = 0;
    logic [ADDR_W-1:0] exp_pc;

    logic              s_rd_en;
    logic              s_ov;
    logic [ADDR_W-1:0] s_rd_addr;
    logic [ADDR_W-1:0] s_opc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, sample 1 ns later, update the stream model.
    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
        bus.out_ready      = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        #1;
        s_rd_en   = bus.imem_rd_en;
        s_rd_addr = bus.imem_rd_address;
        s_ov      = bus.out_valid;
        s_opc     = bus.out_pc;
        if (rv) check("no_issue_on_redirect", {31'd0, s_rd_en}, 32'd0);
        if (s_ov && rdy) begin
            check("stream_pc", s_opc, exp_pc);
            check("stream_insn", bus.out_insn, exp_pc ^ KEY);
            exp_pc = exp_pc + PC_STEP;
            n_xfer++;
        end
        if (rv) exp_pc = rpc & ~32'h3;
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        int base;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;

        #1;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_rd_en", {31'd0, bus.imem_rd_en}, 32'd0);
        check("rst_out_pc", bus.out_pc, 32'd0);
        check("rst_out_insn", bus.out_insn, 32'd0);

        @(negedge clk);
        @(negedge clk);
        reset  = 1'b0;
        exp_pc = RESET_PC;
        cyc    = 0;

        // Startup timing and back-pressure
        step(1'b1, 1'b0, 32'd0);
        check("c0_rd_en", {31'd0, s_rd_en}, 32'd1);
        check("c0_rd_addr", s_rd_addr, 32'h0);
        check("c0_out_valid", {31'd0, s_ov}, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("c1_out_valid", {31'd0, s_ov}, 32'd0);
        check("c1_rd_addr", s_rd_addr, 32'h4);
        step(1'b1, 1'b0, 32'd0);
        check("c2_out_valid", {31'd0, s_ov}, 32'd1);
        check("c2_out_pc", s_opc, 32'h0);
        step(1'b1, 1'b0, 32'd0);
        check("c3_out_pc", s_opc, 32'h4);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'd0);
            check("stall_rd_en", {31'd0, s_rd_en}, 32'd0);
            check("stall_out_valid", {31'd0, s_ov}, 32'd1);
            check("stall_out_pc", s_opc, 32'h8);
        end
        step(1'b1, 1'b0, 32'd0);
        check("release_rd_en", {31'd0, s_rd_en}, 32'd1);
        check("release_rd_addr", s_rd_addr, 32'h10);
        check("release_out_pc", s_opc, 32'h8);
        step(1'b1, 1'b0, 32'd0);
        check("release_next_pc", s_opc, 32'hC);
        step(1'b1, 1'b0, 32'd0);
        check("release_next2_pc", s_opc, 32'h10);

        // Asynchronous reset with buffered data and a read outstanding
        step(1'b0, 1'b0, 32'd0);
        check("pre_reset_out_valid", {31'd0, s_ov}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("async_rst_rd_en", {31'd0, bus.imem_rd_en}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b0;
        exp_pc = RESET_PC;
        cyc    = 0;

        // Restart then redirect in cycle 6
        step(1'b1, 1'b0, 32'd0);
        check("restart_rd_addr", s_rd_addr, RESET_PC);
        check("restart_rd_en", {31'd0, s_rd_en}, 32'd1);
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("restart_out_pc", s_opc, RESET_PC);
        check("restart_out_valid", {31'd0, s_ov}, 32'd1);
        for (int i = 3; i < 6; i++) step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'h103);
        step(1'b1, 1'b0, 32'd0);
        check("redir_r1_rd_en", {31'd0, s_rd_en}, 32'd1);
        check("redir_r1_rd_addr", s_rd_addr, 32'h100);
        check("redir_r1_out_valid", {31'd0, s_ov}, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("redir_r2_out_valid", {31'd0, s_ov}, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("redir_r3_out_valid", {31'd0, s_ov}, 32'd1);
        check("redir_r3_out_pc", s_opc, 32'h100);

        // Redirect together with an accepted pop while the queue is full
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        check("full_rd_en", {31'd0, s_rd_en}, 32'd0);
        check("full_out_pc", s_opc, 32'h104);
        step(1'b1, 1'b1, 32'h200);
        step(1'b1, 1'b0, 32'd0);
        check("full_redir_r1_out_valid", {31'd0, s_ov}, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("full_redir_r2_out_valid", {31'd0, s_ov}, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("full_redir_r3_out_pc", s_opc, 32'h200);

        // Address wrap at the top of the space
        step(1'b1, 1'b1, 32'hFFFF_FFF9);
        step(1'b1, 1'b0, 32'd0);
        check("wrap_addr0", s_rd_addr, 32'hFFFF_FFF8);
        step(1'b1, 1'b0, 32'd0);
        check("wrap_addr1", s_rd_addr, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'd0);
        check("wrap_addr2", s_rd_addr, 32'h0000_0000);
        check("wrap_addr2_en", {31'd0, s_rd_en}, 32'd1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'd0);

        // Random back-pressure and redirects
        base = n_xfer;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, $urandom);
        end
        check("random_progress", {31'd0, (n_xfer - base) > 50}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
